// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation classes and small decode helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;

    function automatic logic [2:0] alu_op_for(input logic [5:0] op);
        case (op)
            OP_RTYPE: return ALU_RTYPE;
            OP_BEQ:   return ALU_SUB;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Branch displacement in bytes: word offset sign-extended, scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without an acknowledge and flags the cycle
// in which the LIMIT-th such cycle is reached.
module fetch_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback
// sequencing, PC and instruction register, sticky error and fetch watchdog.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        zero_flag,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        reg_write,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic [2:0]  alu_op,
    output logic        busy,
    output logic        err,
    output logic [2:0]  state_o
);

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] inst_q, inst_next;
    logic        err_q, err_next;
    logic [5:0]  opcode;
    logic        wd_clear, wd_enable, wd_expired;

    assign opcode = inst_q[31:26];

    assign wd_clear  = (state != ST_FETCH);
    assign wd_enable = (state == ST_FETCH) && !imem_ack;

    fetch_watchdog #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc_q   <= RESET_PC;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            inst_q <= inst_next;
            err_q  <= err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_next = state;
        pc_next    = pc_q;
        inst_next  = inst_q;
        err_next   = err_q;
        imem_req   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;

        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_next  = imem_rdata;
                    pc_next    = pc_q + 32'd4;
                    state_next = ST_DECODE;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_next = ST_EXEC;
                    OP_HALT:                        state_next = ST_HALT;
                    default: begin
                        err_next   = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_op = alu_op_for(opcode);
                case (opcode)
                    OP_RTYPE:     state_next = ST_WB;
                    OP_LW, OP_SW: state_next = ST_MEM;
                    default: begin
                        // Only beq reaches here; pc already points past it.
                        if (zero_flag) pc_next = pc_q + branch_offset(inst_q[15:0]);
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                alu_op = alu_op_for(opcode);
                if (opcode == OP_SW) begin
                    mem_write  = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                alu_op     = alu_op_for(opcode);
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LW);
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pc      = pc_q;
    assign inst    = inst_q;
    assign err     = err_q;
    assign busy    = (state != ST_IDLE) && (state != ST_HALT);
    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        zero_flag = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        reg_write, mem_write, mem_to_reg;
    logic [2:0]  alu_op;
    logic        busy, err;
    logic [2:0]  state_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = '0;
    logic        exp_err = 1'b0;

    multicycle_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .zero_flag  (zero_flag),
        .imem_req   (imem_req),
        .pc         (pc),
        .inst       (inst),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .busy       (busy),
        .err        (err),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_strobes", 32'({imem_req, reg_write, mem_write, mem_to_reg, busy}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_strobes", 32'({imem_req, reg_write, mem_write, mem_to_reg}), 32'h0);
        check("rst_release_state", 32'(state_o), 32'(ST_IDLE));
        exp_pc  = 32'h0;
        exp_err = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_state", 32'(state_o), 32'(ST_FETCH));
        check("start_busy", 32'(busy), 32'h1);
    endtask

    // Executes one instruction starting from a FETCH cycle and compares the
    // observed cycle-level behaviour with what the instruction should do.
    task automatic run_instr(input logic [31:0] word, input logic zf, input int delay);
        logic [5:0]  op;
        int          exp_lat, lat, rw_at, mw_at, rw_cnt, mw_cnt;
        int          m2r_bad, alu_bad, req_bad, busy_bad, off;
        logic [2:0]  exp_alu;
        logic        exp_rw, exp_mw, exp_m2r, exp_halt, alu_valid;
        logic [31:0] next_pc;

        op = word[31:26];
        exp_rw = 0; exp_mw = 0; exp_m2r = 0; exp_halt = 0; alu_valid = 1; exp_alu = 3'b000;
        case (op)
            6'b000000: begin exp_lat = 4; exp_rw = 1; exp_alu = 3'b010; end
            6'b100011: begin exp_lat = 5; exp_rw = 1; exp_m2r = 1; exp_alu = 3'b000; end
            6'b101011: begin exp_lat = 4; exp_mw = 1; exp_alu = 3'b000; end
            6'b000100: begin exp_lat = 3; exp_alu = 3'b001; end
            6'b111111: begin exp_lat = 2; exp_halt = 1; alu_valid = 0; end
            default:   begin exp_lat = 2; alu_valid = 0; exp_err = 1'b1; end
        endcase
        next_pc = exp_pc + 32'd4;
        if (op == 6'b000100 && zf) begin
            off = $signed(word[15:0]);
            next_pc = next_pc + 32'(off * 4);
        end

        zero_flag = zf;
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        check("fetch_pc", pc, exp_pc);
        check("fetch_req", 32'(imem_req), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);

        lat = 1; rw_at = 0; mw_at = 0; rw_cnt = 0; mw_cnt = 0;
        m2r_bad = 0; alu_bad = 0; req_bad = 0; busy_bad = 0;
        while (state_o != ST_FETCH && state_o != ST_HALT && lat < 12) begin
            lat++;
            if (reg_write) begin
                rw_cnt++;
                rw_at = lat;
                if (mem_to_reg !== exp_m2r) m2r_bad++;
            end else if (mem_to_reg) begin
                m2r_bad++;
            end
            if (mem_write) begin
                mw_cnt++;
                mw_at = lat;
            end
            if (imem_req) req_bad++;
            if (!busy) busy_bad++;
            if (alu_valid && lat >= 3 && alu_op !== exp_alu) alu_bad++;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            start      = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_ack = 1'b0;
        start    = 1'b0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("reg_write_count", 32'(rw_cnt), 32'(exp_rw));
        if (exp_rw) check("reg_write_cycle", 32'(rw_at), 32'(exp_lat));
        check("mem_write_count", 32'(mw_cnt), 32'(exp_mw));
        if (exp_mw) check("mem_write_cycle", 32'(mw_at), 32'(exp_lat));
        check("mem_to_reg_bad", 32'(m2r_bad), 32'h0);
        check("alu_op_bad", 32'(alu_bad), 32'h0);
        check("req_outside_fetch", 32'(req_bad), 32'h0);
        check("busy_drop", 32'(busy_bad), 32'h0);
        check("end_state", 32'(state_o), exp_halt ? 32'(ST_HALT) : 32'(ST_FETCH));
        check("pc", pc, next_pc);
        check("inst_hold", inst, word);
        check("err", 32'(err), 32'(exp_err));
        exp_pc = next_pc;
    endtask

    function automatic logic [31:0] rand_legal_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0:       w[31:26] = 6'b000000;
            1:       w[31:26] = 6'b100011;
            2:       w[31:26] = 6'b101011;
            default: w[31:26] = 6'b000100;
        endcase
        return w;
    endfunction

    initial begin
        int rw_seen, bad;

        #2;
        do_reset();
        start_run();

        // Directed instruction sequence.
        run_instr(32'h0022_1820, 1'b0, 0);
        check("add_pc4", pc, 32'h4);
        run_instr(32'h8C22_0004, 1'b0, 0);
        run_instr(32'h1022_FFFF, 1'b1, 0);
        check("beq_taken_pc", pc, 32'h8);
        run_instr(32'h1022_FFFF, 1'b0, 0);
        check("beq_not_taken_pc", pc, 32'hC);
        run_instr(32'hAC22_0004, 1'b0, 0);

        // Randomized legal instruction stream with random ack delays.
        for (int n = 0; n < 40; n++) begin
            run_instr(rand_legal_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end

        run_instr(32'h3C00_1234, 1'b0, 1);
        for (int n = 0; n < 5; n++) begin
            run_instr(rand_legal_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        run_instr(32'hFC00_0000, 1'b0, 0);
        check("halt_busy", 32'(busy), 32'h0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("halt_ignores_start", 32'(state_o), 32'(ST_HALT));
        check("halt_err_sticky", 32'(err), 32'h1);

        // PC wrap-around.
        do_reset();
        start_run();
        run_instr(32'h1000_FFFE, 1'b1, 0);
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        run_instr(32'h0022_1820, 1'b0, 2);
        check("wrap_post", pc, 32'h0);

        // Reset during MEM of a lw aborts it.
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C22_0004;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lw_in_mem", 32'(state_o), 32'(ST_MEM));
        do_reset();
        rw_seen = 0;
        repeat (4) begin
            if (reg_write) rw_seen++;
            @(negedge clk);
        end
        check("abort_no_reg_write", 32'(rw_seen), 32'h0);
        check("abort_idle", 32'(state_o), 32'(ST_IDLE));

        // Fetch timeout.
        start_run();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (state_o != ST_FETCH || !imem_req) bad++;
            imem_ack = 1'b0;
            @(negedge clk);
        end
        check("timeout_fetch_window", 32'(bad), 32'h0);
        check("timeout_state", 32'(state_o), 32'(ST_HALT));
        check("timeout_err", 32'(err), 32'h1);
        check("timeout_req", 32'(imem_req), 32'h0);
        check("timeout_busy", 32'(busy), 32'h0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("timeout_ignores_start", 32'(state_o), 32'(ST_HALT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16, maximum cycles spent in FETCH without imem_ack.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  pulse that leaves IDLE and begins fetching at the current PC.
REQ-006 imem_ack  in  1  instruction memory has imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 zero_flag  in  1  ALU zero result from the datapath (ZeF).
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 pc  out  32  current program counter, also the fetch address.
REQ-011 inst  out  32  instruction register contents driven to the datapath.
REQ-012 reg_write, mem_write, mem_to_reg  out  1 each  datapath strobes.
REQ-013 alu_op  out  3  ALU operation class.
REQ-014 busy  out  1  high in every state except IDLE and HALT.
REQ-015 err  out  1  sticky error: fetch timeout or illegal opcode.
REQ-016 state_o  out  3  current state encoding, for debug.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-018 IDLE -> FETCH when start=1; start is ignored in every other state.
REQ-019 FETCH: imem_req=1; on imem_ack, inst <= imem_rdata, pc <= pc+4, go to DECODE.
REQ-020 FETCH watchdog counts cycles without ack; on reaching FETCH_TIMEOUT, set err, drop imem_req, go to HALT.
REQ-021 DECODE: opcode inst[31:26]; 000000 R-type, 100011 lw, 101011 sw, 000100 beq -> EXEC; 111111 -> HALT; any other -> set err, return to FETCH.
REQ-022 alu_op SHALL be 3'b010 for R-type, 3'b000 (add) for lw/sw, 3'b001 (sub) for beq; held from EXEC until leaving WB.
REQ-023 EXEC: R-type -> WB; lw, sw -> MEM; beq -> FETCH.
REQ-024 beq in EXEC with zero_flag=1: pc <= pc + (sign-extended inst[15:0] << 2), arithmetic modulo 2^32; zero_flag=0 leaves pc unchanged.
REQ-025 MEM: sw asserts mem_write for exactly one cycle then -> FETCH; lw -> WB.
REQ-026 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for lw, 0 for R-type; then -> FETCH.
REQ-027 Strobes are Moore outputs of the current state; none is ever asserted outside its state.
REQ-028 Latency with single-cycle ack: R-type 4 cycles, lw 5, sw 4, beq 3.
REQ-029 PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-030 HALT is terminal; only reset leaves it; err is cleared only by reset.
REQ-031 imem_ack outside FETCH is ignored.

Reset
REQ-032 rst_n=0 asynchronously forces state IDLE, pc=RESET_PC, inst=0, err=0, watchdog=0, all strobes 0.
REQ-033 Reset mid-instruction aborts it; no strobe is asserted in the cycle rst_n deasserts.

Structure
REQ-034 Opcode constants, alu_op codes and state encodings SHALL live in a shared package, mips_pkg.
REQ-035 One sub-module, fetch_watchdog (counter with clear/enable/expired), is natural; the FSM stays in multicycle_ctrl.

Verification
REQ-036 Reset, start, ack immediate, inst 32'h0022_1820 (add) -> reg_write pulses in cycle 4, mem_to_reg=0, pc=4.
REQ-037 lw 32'h8C22_0004 -> alu_op 000, reg_write plus mem_to_reg in cycle 5; sw 32'hAC22_0004 -> one mem_write pulse, no reg_write.
REQ-038 beq 32'h1022_FFFF at pc=8 with zero_flag=1 -> pc=8; with zero_flag=0 -> pc=12.
REQ-039 Withhold imem_ack 16 cycles -> err=1, state HALT, imem_req=0; start ignored afterwards.
REQ-040 Opcode 6'b001111 -> err=1, no strobes, next fetch at pc+4; opcode 111111 -> HALT, busy=0.
REQ-041 Assert rst_n=0 during MEM of a lw -> immediate IDLE, pc=RESET_PC, no reg_write issued.
